// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue: decodes each instruction as it is pushed and
// presents the stored decode of the oldest entry on registered id_* outputs.
module decode_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        if_ready,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [12:0] id_controls,
  output logic [4:0]  id_alucontrol,
  output logic [31:0] id_ext_imm,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic        id_in_slot
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [4:0] NO_CONTROL    = 5'd0;
  localparam logic [4:0] AND_CONTROL   = 5'd1;
  localparam logic [4:0] OR_CONTROL    = 5'd2;
  localparam logic [4:0] XOR_CONTROL   = 5'd3;
  localparam logic [4:0] NOR_CONTROL   = 5'd4;
  localparam logic [4:0] ADD_CONTROL   = 5'd5;
  localparam logic [4:0] ADDU_CONTROL  = 5'd6;
  localparam logic [4:0] SUB_CONTROL   = 5'd7;
  localparam logic [4:0] SUBU_CONTROL  = 5'd8;
  localparam logic [4:0] SLT_CONTROL   = 5'd9;
  localparam logic [4:0] SLTU_CONTROL  = 5'd10;
  localparam logic [4:0] SLL_CONTROL   = 5'd11;
  localparam logic [4:0] SRL_CONTROL   = 5'd12;
  localparam logic [4:0] SRA_CONTROL   = 5'd13;
  localparam logic [4:0] SLLV_CONTROL  = 5'd14;
  localparam logic [4:0] SRLV_CONTROL  = 5'd15;
  localparam logic [4:0] SRAV_CONTROL  = 5'd16;
  localparam logic [4:0] LUI_CONTROL   = 5'd17;
  localparam logic [4:0] MULT_CONTROL  = 5'd18;
  localparam logic [4:0] MULTU_CONTROL = 5'd19;
  localparam logic [4:0] DIV_CONTROL   = 5'd20;
  localparam logic [4:0] DIVU_CONTROL  = 5'd21;

  // Control word: {regwrite,regdst,alusrc,branch,memen,memtoreg,jump,jal,jr,bal,memwrite,next_is_in_slot,invalid}
  localparam logic [12:0] CTL_INVALID = 13'b0000000000001;
  localparam logic [12:0] CTL_RTYPE   = 13'b1100000000000;
  localparam logic [12:0] CTL_HILO    = 13'b0100000000000;
  localparam logic [12:0] CTL_JR      = 13'b0000001010010;
  localparam logic [12:0] CTL_JALR    = 13'b1100000010010;
  localparam logic [12:0] CTL_LOAD    = 13'b1010110000000;
  localparam logic [12:0] CTL_STORE   = 13'b0010100000100;
  localparam logic [12:0] CTL_BRANCH  = 13'b0001000000010;
  localparam logic [12:0] CTL_BRLINK  = 13'b1001000001010;
  localparam logic [12:0] CTL_IMM     = 13'b1010000000000;
  localparam logic [12:0] CTL_J       = 13'b0000001000010;
  localparam logic [12:0] CTL_JAL     = 13'b1000000100010;
  localparam logic [12:0] CTL_MFC0    = 13'b1000000000000;
  localparam logic [12:0] CTL_MTC0    = 13'b0100000000000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [12:0] controls;
    logic [4:0]  alucontrol;
    logic [31:0] ext_imm;
    logic        in_slot;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             new_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               slot_flag;
  logic               push, pop;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;
  logic [12:0] dec_ctl;
  logic [4:0]  dec_alu;
  logic [31:0] dec_imm;

  assign op    = if_inst[31:26];
  assign rs    = if_inst[25:21];
  assign rt    = if_inst[20:16];
  assign funct = if_inst[5:0];

  assign if_ready = (count != CNT_W'(DEPTH)) & ~rst & ~flush;
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;

  // NOTE: every variable assigned in a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    dec_ctl = CTL_INVALID;
    case (op)
      6'h00: begin
        case (funct)
          6'h08:                      dec_ctl = CTL_JR;
          6'h09:                      dec_ctl = CTL_JALR;
          6'h0C, 6'h0D:               dec_ctl = '0;
          6'h18, 6'h19, 6'h1A, 6'h1B: dec_ctl = CTL_HILO;
          default:                    dec_ctl = CTL_RTYPE;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: dec_ctl = CTL_BRANCH;
          5'h10, 5'h11: dec_ctl = CTL_BRLINK;
          default:      dec_ctl = CTL_INVALID;
        endcase
      end
      6'h02:                                           dec_ctl = CTL_J;
      6'h03:                                           dec_ctl = CTL_JAL;
      6'h04, 6'h05:                                    dec_ctl = CTL_BRANCH;
      6'h06, 6'h07:                                    dec_ctl = (rt == '0) ? CTL_BRANCH : CTL_INVALID;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: dec_ctl = CTL_IMM;
      6'h0F:                                           dec_ctl = (rs == '0) ? CTL_IMM : CTL_INVALID;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25:               dec_ctl = CTL_LOAD;
      6'h28, 6'h29, 6'h2B:                             dec_ctl = CTL_STORE;
      default:                                         dec_ctl = CTL_INVALID;
    endcase
    // Whole-word matches (NOP, ERET, MFC0/MTC0) win over the opcode table.
    if (if_inst == '0 || if_inst == 32'h42000018)
      dec_ctl = '0;
    else if (if_inst[31:21] == 11'h200 && if_inst[10:0] == '0)
      dec_ctl = CTL_MFC0;
    else if (if_inst[31:21] == 11'h204 && if_inst[10:0] == '0)
      dec_ctl = CTL_MTC0;
  end

  always_comb begin
    dec_alu = NO_CONTROL;
    case (op)
      6'h00: begin
        case (funct)
          6'h00:   dec_alu = SLL_CONTROL;
          6'h02:   dec_alu = SRL_CONTROL;
          6'h03:   dec_alu = SRA_CONTROL;
          6'h04:   dec_alu = SLLV_CONTROL;
          6'h06:   dec_alu = SRLV_CONTROL;
          6'h07:   dec_alu = SRAV_CONTROL;
          6'h18:   dec_alu = MULT_CONTROL;
          6'h19:   dec_alu = MULTU_CONTROL;
          6'h1A:   dec_alu = DIV_CONTROL;
          6'h1B:   dec_alu = DIVU_CONTROL;
          6'h20:   dec_alu = ADD_CONTROL;
          6'h21:   dec_alu = ADDU_CONTROL;
          6'h22:   dec_alu = SUB_CONTROL;
          6'h23:   dec_alu = SUBU_CONTROL;
          6'h24:   dec_alu = AND_CONTROL;
          6'h25:   dec_alu = OR_CONTROL;
          6'h26:   dec_alu = XOR_CONTROL;
          6'h27:   dec_alu = NOR_CONTROL;
          6'h2A:   dec_alu = SLT_CONTROL;
          6'h2B:   dec_alu = SLTU_CONTROL;
          default: dec_alu = NO_CONTROL;
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
      6'h28, 6'h29, 6'h2B: dec_alu = ADD_CONTROL;
      6'h08:   dec_alu = ADD_CONTROL;
      6'h09:   dec_alu = ADDU_CONTROL;
      6'h0A:   dec_alu = SLT_CONTROL;
      6'h0B:   dec_alu = SLTU_CONTROL;
      6'h0C:   dec_alu = AND_CONTROL;
      6'h0D:   dec_alu = OR_CONTROL;
      6'h0E:   dec_alu = XOR_CONTROL;
      6'h0F:   dec_alu = LUI_CONTROL;
      default: dec_alu = NO_CONTROL;
    endcase
  end

  assign dec_imm = (op[3:2] == 2'b11) ? {16'h0000, if_inst[15:0]}
                                      : {{16{if_inst[15]}}, if_inst[15:0]};

  assign new_entry = '{pc: if_pc, inst: if_inst, controls: dec_ctl,
                       alucontrol: dec_alu, ext_imm: dec_imm, in_slot: slot_flag};

  // NOTE: entry storage has no reset; id_* outputs are forced to their empty values whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      slot_flag <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        slot_flag <= dec_ctl[1];
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    id_pc         = RESET_PC;
    id_inst       = '0;
    id_controls   = '0;
    id_alucontrol = '0;
    id_ext_imm    = '0;
    id_rs         = '0;
    id_rt         = '0;
    id_rd         = '0;
    id_in_slot    = 1'b0;
    if (id_valid) begin
      id_pc         = head.pc;
      id_inst       = head.inst;
      id_controls   = head.controls;
      id_alucontrol = head.alucontrol;
      id_ext_imm    = head.ext_imm;
      id_rs         = head.inst[25:21];
      id_rt         = head.inst[20:16];
      id_rd         = head.inst[15:11];
      id_in_slot    = head.in_slot;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: stimulus pushes hand-decoded expectations into a
// scoreboard, and a negedge monitor checks each entry as execute consumes it.
module tb_decode_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  localparam logic [4:0] A_NO = 5'd0, A_AND = 5'd1, A_OR = 5'd2, A_XOR = 5'd3, A_ADD = 5'd5,
                         A_ADDU = 5'd6, A_LUI = 5'd17, A_MULT = 5'd18;

  localparam logic [12:0] C_IMM = 13'b1010000000000, C_LOAD = 13'b1010110000000,
                          C_STORE = 13'b0010100000100, C_RTYPE = 13'b1100000000000,
                          C_JAL = 13'b1000000100010, C_BRANCH = 13'b0001000000010,
                          C_J = 13'b0000001000010, C_INV = 13'b0000000000001,
                          C_MFC0 = 13'b1000000000000, C_JR = 13'b0000001010010,
                          C_HILO = 13'b0100000000000, C_BRLINK = 13'b1001000001010;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, if_ready, id_valid, id_ready, id_in_slot;
  logic [31:0] if_pc, if_inst, id_pc, id_inst, id_ext_imm;
  logic [12:0] id_controls;
  logic [4:0]  id_alucontrol, id_rs, id_rt, id_rd;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [12:0] ctl;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic        slot;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  decode_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_controls(id_controls),
    .id_alucontrol(id_alucontrol), .id_ext_imm(id_ext_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_in_slot(id_in_slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && !flush && id_valid && id_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pop_unexpected: got id_pc %h id_inst %h, expected no entry", id_pc, id_inst);
      end else begin
        e = sb.pop_front();
        check("pop_pc", id_pc, e.pc);
        check("pop_inst", id_inst, e.inst);
        check("pop_controls", 32'(id_controls), 32'(e.ctl));
        check("pop_alu", 32'(id_alucontrol), 32'(e.alu));
        check("pop_ext_imm", id_ext_imm, e.imm);
        check("pop_regs", 32'({id_rs, id_rt, id_rd}), 32'(e.inst[25:11]));
        check("pop_in_slot", 32'(id_in_slot), 32'(e.slot));
      end
    end
  end

  task automatic check_empty(input string tag);
    check({tag, "_id_valid"}, 32'(id_valid), 0);
    check({tag, "_id_pc"}, id_pc, RESET_PC);
    check({tag, "_id_other"}, 32'(|{id_inst, id_controls, id_alucontrol, id_ext_imm,
                                   id_rs, id_rt, id_rd, id_in_slot}), 0);
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic [12:0] ctl,
                      input logic [4:0] alu, input logic [31:0] imm, input bit slot,
                      input bit accept, input bit pop_too);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = pop_too;
    @(negedge clk);
    check("if_ready", 32'(if_ready), 32'(accept));
    @(posedge clk); #1;
    if_valid = 1'b0;
    id_ready = 1'b0;
    if (accept) sb.push_back('{pc, inst, ctl, alu, imm, slot});
  endtask

  task automatic drain(input string tag);
    id_ready = 1'b1;
    for (int c = 0; c < 4 * DEPTH && sb.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    id_ready = 1'b0;
    check({tag, "_drained"}, sb.size(), 0);
    sb.delete();
    @(negedge clk);
    check_empty(tag);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_ready", 32'(if_ready), 0);
    check_empty("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_if_ready", 32'(if_ready), 1);
    check_empty("idle");
    @(posedge clk); #1;

    // ORI lands at the head one cycle after the push, never in the push cycle.
    if_valid = 1'b1; if_pc = 32'hBFC00000; if_inst = 32'h34081234;
    @(negedge clk);
    check("ori_no_bypass", 32'(id_valid), 0);
    @(posedge clk); #1;
    if_valid = 1'b0;
    sb.push_back('{32'hBFC00000, 32'h34081234, C_IMM, A_OR, 32'h00001234, 1'b0});
    @(negedge clk);
    check("ori_head_valid", 32'(id_valid), 1);
    check("ori_head_controls", 32'(id_controls), 32'(C_IMM));
    check("ori_head_ext_imm", id_ext_imm, 32'h00001234);
    @(posedge clk); #1;
    drain("ori");

    // Fill to DEPTH without consuming; the fifth offer is refused.
    push(32'h100, 32'h2402FFFF, C_IMM,   A_ADDU, 32'hFFFFFFFF, 0, 1, 0);
    push(32'h104, 32'h8C430008, C_LOAD,  A_ADD,  32'h00000008, 0, 1, 0);
    push(32'h108, 32'hAC43FFFC, C_STORE, A_ADD,  32'hFFFFFFFC, 0, 1, 0);
    push(32'h10C, 32'h00432020, C_RTYPE, A_ADD,  32'h00002020, 0, 1, 0);
    push(32'h110, 32'h24090001, C_IMM,   A_ADDU, 32'h00000001, 0, 0, 0);
    drain("full");

    // Delay-slot tagging follows the previous push's next_is_in_slot.
    push(32'h200, 32'h0C000010, C_JAL,    A_NO,  32'h00000010, 0, 1, 0);
    push(32'h204, 32'h24050007, C_IMM,    A_ADDU, 32'h00000007, 1, 1, 0);
    push(32'h208, 32'h10220003, C_BRANCH, A_NO,  32'h00000003, 0, 1, 0);
    push(32'h20C, 32'h38A600FF, C_IMM,    A_XOR, 32'h000000FF, 1, 1, 0);
    drain("slot");

    // Two queued, then 3*DEPTH simultaneous push+pop cycles across the pointer wrap.
    for (int i = 0; i < 2 + 3 * DEPTH; i++)
      push(32'h300 + 32'(4 * i), 32'h24080000 | 32'(i), C_IMM, A_ADDU, 32'(i), 0, 1, i >= 2);
    push(32'h380, 32'h24080040, C_IMM, A_ADDU, 32'h00000040, 0, 1, 0);
    push(32'h384, 32'h24080041, C_IMM, A_ADDU, 32'h00000041, 0, 1, 0);
    push(32'h388, 32'h24080042, C_IMM, A_ADDU, 32'h00000042, 0, 0, 0);
    drain("wrap");

    // Flush with a concurrent offer and pop; the J's slot flag must not survive.
    push(32'h400, 32'h20010005, C_IMM, A_ADD, 32'h00000005, 0, 1, 0);
    push(32'h404, 32'h34020003, C_IMM, A_OR,  32'h00000003, 0, 1, 0);
    push(32'h408, 32'h08000040, C_J,   A_NO,  32'h00000040, 0, 1, 0);
    flush = 1'b1; if_valid = 1'b1; if_pc = 32'h500; if_inst = 32'h24040063; id_ready = 1'b1;
    @(negedge clk);
    check("flush_if_ready", 32'(if_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    check_empty("flush");
    @(posedge clk); #1;
    push(32'h504, 32'h24030009, C_IMM, A_ADDU, 32'h00000009, 0, 1, 0);
    drain("post_flush");

    // Invalid encodings and whole-word overrides.
    push(32'h600, 32'hFC000000, C_INV,  A_NO,  32'h00000000, 0, 1, 0);
    push(32'h604, 32'h3C211234, C_INV,  A_LUI, 32'h00001234, 0, 1, 0);
    push(32'h608, 32'h42000018, 13'b0,  A_NO,  32'h00000018, 0, 1, 0);
    push(32'h60C, 32'h40026000, C_MFC0, A_NO,  32'h00006000, 0, 1, 0);
    drain("override");
    push(32'h700, 32'h03E00008, C_JR,     A_NO,   32'h00000008, 0, 1, 0);
    push(32'h704, 32'h00430018, C_HILO,   A_MULT, 32'h00000018, 1, 1, 0);
    push(32'h708, 32'h04510004, C_BRLINK, A_NO,   32'h00000004, 0, 1, 0);
    push(32'h70C, 32'h1C210002, C_INV,    A_NO,   32'h00000002, 1, 1, 0);
    drain("branch_mix");

    // Reset mid-operation outranks flush, push and pop, and clears the slot flag.
    push(32'h800, 32'h34020003, C_IMM, A_OR, 32'h00000003, 0, 1, 0);
    push(32'h804, 32'h08000040, C_J,   A_NO, 32'h00000040, 0, 1, 0);
    rst = 1'b1; flush = 1'b1; if_valid = 1'b1; if_inst = 32'h24040063; id_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_if_ready", 32'(if_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    sb.delete();
    @(negedge clk);
    check_empty("rst_mid");
    @(posedge clk); #1;
    push(32'h900, 32'h34020003, C_IMM, A_OR, 32'h00000003, 0, 1, 0);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
